// File: rtl/frame_buffer_ctrl.sv
// Frame store initiator: captures one frame of 16-bit pixels into the SPRAM and streams it back over valid/ready.
// Optional double buffering across two 32K-word banks is enabled with `define FB_PINGPONG_EN.
module frame_buffer_ctrl #(
    parameter int FRAME_WORDS = 19200,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_ram,
    input  logic              rst,
    input  logic              wr_start,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [15:0]       rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_wren,
    input  logic [15:0]       ram_dout,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]         ram_din_q, ram_din_d;
    logic                ram_wren_q, ram_wren_d;
    logic                rd_valid_q, rd_valid_d;
    logic [15:0]         rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]   wr_base;
    logic [ADDR_W-1:0]   rd_base;
    logic                cnt_last;

    assign cnt_last = (cnt_q == LAST_IDX);

`ifdef FB_PINGPONG_EN
    // last_bank_q names the bank holding the most recent complete frame; capture targets the other one.
    logic last_bank_q, last_bank_d;

    assign wr_base = {~last_bank_q, {(ADDR_W-1){1'b0}}};
    assign rd_base = { last_bank_q, {(ADDR_W-1){1'b0}}};

    always_comb begin
        last_bank_d = last_bank_q;
        if (state_q == CAPTURE && pix_valid && cnt_last) begin
            last_bank_d = ~last_bank_q;
        end
    end

    always_ff @(posedge clk_ram or posedge rst) begin
        if (rst) begin
            last_bank_q <= 1'b0;
        end else begin
            last_bank_q <= last_bank_d;
        end
    end
`else
    assign wr_base = '0;
    assign rd_base = '0;
`endif

    always_ff @(posedge clk_ram or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    state_d = CAPTURE;
                end else if (rd_start) begin
                    state_d = RD_ISSUE;
                end
            end
            CAPTURE: begin
                if (pix_valid && cnt_last) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_HOLD;
            RD_HOLD: begin
                if (rd_ready) begin
                    state_d = cnt_last ? IDLE : RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The read address is registered on entry to RD_ISSUE, so the SPRAM samples it
    // during RD_ISSUE and its data is ready to be captured at the end of RD_WAIT.
    always_comb begin
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_wren_d   = 1'b0;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        frame_done_d = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    cnt_d = '0;
                end else if (rd_start) begin
                    cnt_d      = '0;
                    ram_addr_d = rd_base;
                end
            end
            CAPTURE: begin
                if (pix_valid) begin
                    ram_addr_d = wr_base + cnt_q;
                    ram_din_d  = pix_data;
                    ram_wren_d = 1'b1;
                    if (cnt_last) begin
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            RD_WAIT: begin
                rd_data_d  = ram_dout;
                rd_valid_d = 1'b1;
            end
            RD_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (cnt_last) begin
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + ONE;
                        ram_addr_d = rd_base + cnt_q + ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_ram or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_wren_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_wren_q   <= ram_wren_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_wren   = ram_wren_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl (single-bank build): random pixel data, gaps and
// readout stalls checked against a frame-level model of what each write and read should show.
module tb_frame_buffer_ctrl;

    localparam int N = 4;

    logic        clk_ram = 1'b0;
    logic        rst;
    logic        wr_start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        rd_start;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_wren;
    logic [15:0] ram_dout;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] expFrame [N];

    frame_buffer_ctrl #(
        .FRAME_WORDS(N),
        .ADDR_W     (16)
    ) dut (
        .clk_ram   (clk_ram),
        .rst       (rst),
        .wr_start  (wr_start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .rd_start  (rd_start),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_wren  (ram_wren),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk_ram = ~clk_ram;

    // Single-port SPRAM with registered read data.
    always @(posedge clk_ram) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance to the next falling edge to observe the result.
    task automatic applyStimulus(input logic wr, input logic rd, input logic pv,
                                 input logic [15:0] d, input logic rdy);
        wr_start  = wr;
        rd_start  = rd;
        pix_valid = pv;
        pix_data  = d;
        rd_ready  = rdy;
        @(negedge clk_ram);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, ram_addr, 16'h0);
        checkOutput({tag, "_din"}, ram_din, 16'h0);
        checkOutput({tag, "_wren"}, {15'h0, ram_wren}, 16'h0);
        checkOutput({tag, "_rd_valid"}, {15'h0, rd_valid}, 16'h0);
        checkOutput({tag, "_rd_data"}, rd_data, 16'h0);
        checkOutput({tag, "_busy"}, {15'h0, busy}, 16'h0);
        checkOutput({tag, "_frame_done"}, {15'h0, frame_done}, 16'h0);
    endtask

    task automatic captureFrame(input logic simul, input int maxGap);
        logic [15:0] d;
        applyStimulus(1'b1, simul, 1'b0, 16'h0, 1'b0);
        checkOutput("cap_start_busy", {15'h0, busy}, 16'h1);
        checkOutput("cap_start_wren", {15'h0, ram_wren}, 16'h0);
        for (int i = 0; i < N; i++) begin
            int gap;
            gap = $urandom_range(maxGap, 0);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0,
                              16'($urandom), 1'b0);
                checkOutput("cap_gap_wren", {15'h0, ram_wren}, 16'h0);
                checkOutput("cap_gap_busy", {15'h0, busy}, 16'h1);
            end
            d = 16'($urandom);
            expFrame[i] = d;
            applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
            checkOutput("cap_wren", {15'h0, ram_wren}, 16'h1);
            checkOutput("cap_addr", ram_addr, 16'(i));
            checkOutput("cap_din", ram_din, d);
            checkOutput("cap_frame_done", {15'h0, frame_done}, (i == N - 1) ? 16'h1 : 16'h0);
            checkOutput("cap_busy", {15'h0, busy}, (i == N - 1) ? 16'h0 : 16'h1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("cap_end_wren", {15'h0, ram_wren}, 16'h0);
        checkOutput("cap_end_frame_done", {15'h0, frame_done}, 16'h0);
        checkOutput("cap_end_busy", {15'h0, busy}, 16'h0);
    endtask

    task automatic readFrame(input int maxStall, input int forceWord, input int forceLen);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        checkOutput("rd_start_busy", {15'h0, busy}, 16'h1);
        for (int i = 0; i < N; i++) begin
            int lat;
            int stall;
            checkOutput("rd_issue_addr", ram_addr, 16'(i));
            checkOutput("rd_issue_valid", {15'h0, rd_valid}, 16'h0);
            lat = 0;
            while (rd_valid !== 1'b1 && lat < 8) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
                checkOutput("rd_wait_wren", {15'h0, ram_wren}, 16'h0);
                lat++;
            end
            checkOutput("rd_latency", 16'(lat), 16'd2);
            checkOutput("rd_data", rd_data, expFrame[i]);
            stall = (i == forceWord) ? forceLen : $urandom_range(maxStall, 0);
            for (int s = 0; s < stall; s++) begin
                applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0,
                              16'($urandom), 1'b0);
                checkOutput("rd_hold_valid", {15'h0, rd_valid}, 16'h1);
                checkOutput("rd_hold_data", rd_data, expFrame[i]);
                checkOutput("rd_hold_addr", ram_addr, 16'(i));
                checkOutput("rd_hold_wren", {15'h0, ram_wren}, 16'h0);
            end
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            checkOutput("rd_hs_valid", {15'h0, rd_valid}, 16'h0);
            checkOutput("rd_hs_frame_done", {15'h0, frame_done}, (i == N - 1) ? 16'h1 : 16'h0);
            checkOutput("rd_hs_busy", {15'h0, busy}, (i == N - 1) ? 16'h0 : 16'h1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("rd_end_frame_done", {15'h0, frame_done}, 16'h0);
        checkOutput("rd_end_busy", {15'h0, busy}, 16'h0);
    endtask

    initial begin
        rst       = 1'b0;
        wr_start  = 1'b0;
        rd_start  = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 16'h0;
        rd_ready  = 1'b0;
        #1 rst = 1'b1;
        #11;
        checkAllZero("reset");
        @(negedge clk_ram);
        rst = 1'b0;
        @(negedge clk_ram);

        $display("[TB] back-to-back capture, readout with a 5-cycle stall on word 2");
        captureFrame(1'b0, 0);
        readFrame(0, 2, 5);

        $display("[TB] simultaneous wr_start/rd_start, gapped capture, random stalls");
        captureFrame(1'b1, 2);
        readFrame(3, -1, 0);

        $display("[TB] pix_valid ignored while idle");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        checkOutput("idle_pix_wren", {15'h0, ram_wren}, 16'h0);
        checkOutput("idle_pix_busy", {15'h0, busy}, 16'h0);

        $display("[TB] reset in the middle of a capture");
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
        checkOutput("pre_rst_cap_wren", {15'h0, ram_wren}, 16'h1);
        #2 rst = 1'b1;
        #1;
        checkAllZero("rst_cap");
        @(negedge clk_ram);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h9ABC, 1'b0);
        checkOutput("post_rst_wren", {15'h0, ram_wren}, 16'h0);
        checkOutput("post_rst_busy", {15'h0, busy}, 16'h0);

        $display("[TB] reset in the middle of a readout");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("pre_rst_rd_valid", {15'h0, rd_valid}, 16'h1);
        #2 rst = 1'b1;
        #1;
        checkAllZero("rst_rd");
        @(negedge clk_ram);
        rst = 1'b0;
        @(negedge clk_ram);

        $display("[TB] random capture/readout rounds");
        for (int r = 0; r < 3; r++) begin
            captureFrame(1'($urandom_range(1, 0)), 2);
            readFrame(4, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
